// File: rtl/demod_pkg.sv
// rtl/demod_pkg.sv - shared width and saturation helpers for the lock-in demodulator
// Purpose : accumulator width function, signed saturation, abs-with-saturate.
// Ports   : none (package).
// Helpers work on 64-bit longint so one function serves every DW up to 24.
package demod_pkg;

    // Accumulator width: full-precision product plus growth over 2^log2_decim samples.
    function automatic int acc_width(input int dw, input int log2_decim);
        return 2 * dw + log2_decim;
    endfunction

    // Clamp a signed value to the DW-bit two's-complement range.
    function automatic longint sat_dw(input longint x, input int dw);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (dw - 1)) - longint'(1);
        lo = -(longint'(1) <<< (dw - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // |x| for a DW-bit signed value; the most negative code maps to the largest positive.
    function automatic longint abs_sat(input longint x, input int dw);
        longint lo;
        lo = -(longint'(1) <<< (dw - 1));
        if (x == lo) begin
            return (longint'(1) <<< (dw - 1)) - longint'(1);
        end
        return (x < 0) ? -x : x;
    endfunction

endpackage

// File: rtl/demod_acc.sv
// rtl/demod_acc.sv - one demodulator channel: multiply, integrate, dump, saturate
// Purpose : registers sig_in*ref_in, accumulates products over a window and
//           presents the saturated window average combinationally on res_o.
// Ports   : clk, rst_n       clock, async active-low reset
//           ce_in            load a new product
//           clr              zero the accumulator (highest priority)
//           ce_p             product register holds a valid sample
//           wrap             current sample is the last of the window
//           sig_in, ref_in   signed DW-bit operands
//           res_o            saturated average of the window ending with this product
module demod_acc
    import demod_pkg::*;
#(
    parameter int DW         = 16,
    parameter int LOG2_DECIM = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce_in,
    input  logic                 clr,
    input  logic                 ce_p,
    input  logic                 wrap,
    input  logic signed [DW-1:0] sig_in,
    input  logic signed [DW-1:0] ref_in,
    output logic signed [DW-1:0] res_o
);

    localparam int AW    = acc_width(DW, LOG2_DECIM);
    // Divide by 2^LOG2_DECIM for the average and by 2^(DW-1) to return to Q1.(DW-1).
    localparam int SHIFT = LOG2_DECIM + DW - 1;

    logic signed [2*DW-1:0] prod_q;
    logic signed [2*DW-1:0] prod_d;
    logic signed [AW-1:0]   acc_q;
    logic signed [AW-1:0]   acc_d;
    logic signed [AW-1:0]   sum;
    logic signed [AW-1:0]   shifted;

    assign prod_d  = (2*DW)'(sig_in) * (2*DW)'(ref_in);
    assign sum     = acc_q + AW'(prod_q);
    assign shifted = sum >>> SHIFT;
    assign res_o   = DW'(sat_dw(64'(shifted), DW));

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (ce_p) begin
            // On the last sample the sum is dumped to the output, so restart at zero.
            acc_d = wrap ? '0 : sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            if (ce_in) begin
                prod_q <= prod_d;
            end
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/lockin_demod.sv
// rtl/lockin_demod.sv - lock-in I/Q demodulator with integrate-and-dump decimation
// Purpose : multiplies signal by DDS cos/sin, averages 2^LOG2_DECIM enabled
//           samples per channel and emits one I/Q pair per window.
// Ports   : clk, rst_n              clock, async active-low reset
//           ce_in                   sample strobe for signal/sin_in/cos_in
//           clr                     restart integration window
//           signal, sin_in, cos_in  signed DW-bit inputs
//           ce_out                  one-cycle pulse when outputs update
//           i_out, q_out            signed window averages
//           mag                     magnitude estimate (DEMOD_MAG_EN only)
// Config  : DEMOD_MAG_EN adds the mag port and one register stage (latency t+3).
module lockin_demod
    import demod_pkg::*;
#(
    parameter int DW         = 16,
    parameter int LOG2_DECIM = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ce_in,
    input  logic                 clr,
    input  logic signed [DW-1:0] signal,
    input  logic signed [DW-1:0] sin_in,
    input  logic signed [DW-1:0] cos_in,
`ifdef DEMOD_MAG_EN
    output logic        [DW-1:0] mag,
`endif
    output logic                 ce_out,
    output logic signed [DW-1:0] i_out,
    output logic signed [DW-1:0] q_out
);

    logic [LOG2_DECIM-1:0] cnt_q;
    logic [LOG2_DECIM-1:0] cnt_d;
    logic                  ce_p_q;
    logic                  ce_p_d;
    logic                  wrap;
    logic                  dump;
    logic signed [DW-1:0]  i_res;
    logic signed [DW-1:0]  q_res;
    logic                  ce_dump_q;
    logic signed [DW-1:0]  i_dump_q;
    logic signed [DW-1:0]  q_dump_q;

    // Counter is exactly LOG2_DECIM bits, so the last sample is all-ones and
    // the increment wraps to zero by itself.
    assign wrap = &cnt_q;
    assign dump = ce_p_q & wrap & ~clr;

    always_comb begin
        cnt_d  = cnt_q;
        ce_p_d = ce_in;
        if (clr) begin
            cnt_d  = '0;
            ce_p_d = 1'b0;
        end else if (ce_p_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            ce_p_q    <= 1'b0;
            ce_dump_q <= 1'b0;
            i_dump_q  <= '0;
            q_dump_q  <= '0;
        end else begin
            cnt_q     <= cnt_d;
            ce_p_q    <= ce_p_d;
            ce_dump_q <= dump;
            if (dump) begin
                i_dump_q <= i_res;
                q_dump_q <= q_res;
            end
        end
    end

    demod_acc #(
        .DW         (DW),
        .LOG2_DECIM (LOG2_DECIM)
    ) u_acc_i (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce_in  (ce_in),
        .clr    (clr),
        .ce_p   (ce_p_q),
        .wrap   (wrap),
        .sig_in (signal),
        .ref_in (cos_in),
        .res_o  (i_res)
    );

    demod_acc #(
        .DW         (DW),
        .LOG2_DECIM (LOG2_DECIM)
    ) u_acc_q (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce_in  (ce_in),
        .clr    (clr),
        .ce_p   (ce_p_q),
        .wrap   (wrap),
        .sig_in (signal),
        .ref_in (sin_in),
        .res_o  (q_res)
    );

`ifdef DEMOD_MAG_EN
    // Alpha-max-plus-beta-min estimate; I/Q are delayed one stage so all
    // outputs update on the same ce_out pulse.
    longint               abs_i;
    longint               abs_q;
    longint               mag_max;
    longint               mag_min;
    longint               mag_sum;
    logic        [DW-1:0] mag_d;
    logic                 ce_out_q;
    logic signed [DW-1:0] i_out_q;
    logic signed [DW-1:0] q_out_q;
    logic        [DW-1:0] mag_q;

    always_comb begin
        abs_i   = abs_sat(longint'(i_dump_q), DW);
        abs_q   = abs_sat(longint'(q_dump_q), DW);
        mag_max = (abs_i > abs_q) ? abs_i : abs_q;
        mag_min = (abs_i > abs_q) ? abs_q : abs_i;
        mag_sum = mag_max + (mag_min >>> 1);
        if (mag_sum > ((longint'(1) <<< DW) - longint'(1))) begin
            mag_sum = (longint'(1) <<< DW) - longint'(1);
        end
        mag_d = DW'(mag_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce_out_q <= 1'b0;
            i_out_q  <= '0;
            q_out_q  <= '0;
            mag_q    <= '0;
        end else begin
            ce_out_q <= ce_dump_q;
            if (ce_dump_q) begin
                i_out_q <= i_dump_q;
                q_out_q <= q_dump_q;
                mag_q   <= mag_d;
            end
        end
    end

    assign ce_out = ce_out_q;
    assign i_out  = i_out_q;
    assign q_out  = q_out_q;
    assign mag    = mag_q;
`else
    assign ce_out = ce_dump_q;
    assign i_out  = i_dump_q;
    assign q_out  = q_dump_q;
`endif

endmodule
